// File: rtl/fetch_pc_if.sv
// fetch_pc_if: control/address bundle between the decode stage and the fetch PC sequencer
// Signals: Start/StartAddr begin a run, Halt/Stall/BranchTaken/PCAddr steer it,
// PC/InstValid/Done report it; CycleCount exists only when CYCLE_CNT_EN is defined.
// Modports: master = decode/environment side, slave = fetch_pc.
interface fetch_pc_if #(parameter int PC_W = 16);
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic            Halt;
  logic            Stall;
  logic            BranchTaken;
  logic [PC_W-1:0] PCAddr;
  logic [PC_W-1:0] PC;
  logic            InstValid;
  logic            Done;
`ifdef CYCLE_CNT_EN
  logic [31:0]     CycleCount;
`endif
  modport master (
    output Start, StartAddr, Halt, Stall, BranchTaken, PCAddr,
`ifdef CYCLE_CNT_EN
    input CycleCount,
`endif
    input PC, InstValid, Done
  );
  modport slave (
    input Start, StartAddr, Halt, Stall, BranchTaken, PCAddr,
`ifdef CYCLE_CNT_EN
    output CycleCount,
`endif
    output PC, InstValid, Done
  );
endinterface

// File: rtl/fetch_pc.sv
// fetch_pc: program counter and fetch sequencer for the Divvy core
// Ports: CLK (rising edge), Reset_n (asynchronous, active low),
//   bus (fetch_pc_if.slave): Start/StartAddr, Halt, Stall, BranchTaken/PCAddr in; PC, InstValid, Done out.
// Optional macro CYCLE_CNT_EN adds bus.CycleCount, a saturating count of cycles spent in RUN.
module fetch_pc #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] MAX_ADDR = 16'hFFFF
) (
  input logic       CLK,
  input logic       Reset_n,
  fetch_pc_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t          state;
  logic [PC_W-1:0] pc;
  logic            inst_valid;
  logic            done;
  assign bus.PC        = pc;
  assign bus.InstValid = inst_valid;
  assign bus.Done      = done;
  // Falling off MAX_ADDR ends the run only on a plain sequential step; branches are unchecked.
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      state      <= IDLE;
      pc         <= '0;
      inst_valid <= 1'b0;
      done       <= 1'b0;
    end else
      case (state)
        IDLE, DONE:
          if (bus.Start) begin
            state      <= RUN;
            pc         <= bus.StartAddr;
            inst_valid <= 1'b1;
            done       <= 1'b0;
          end
        RUN:
          if (bus.Start)
            pc <= bus.StartAddr;
          else if (bus.Halt || (!bus.Stall && !bus.BranchTaken && pc == MAX_ADDR)) begin
            state      <= DONE;
            inst_valid <= 1'b0;
            done       <= 1'b1;
          end else if (!bus.Stall)
            pc <= bus.BranchTaken ? bus.PCAddr : pc + PC_W'(1);
        default: begin
          state      <= IDLE;
          inst_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
`ifdef CYCLE_CNT_EN
  logic [31:0] cycle_count;
  assign bus.CycleCount = cycle_count;
  // Every edge taken in RUN counts (stalls and the ending edge included); a restart clears instead.
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n)
      cycle_count <= '0;
    else if (bus.Start && state inside {IDLE, RUN, DONE})
      cycle_count <= '0;
    else if (state == RUN && cycle_count != '1)
      cycle_count <= cycle_count + 32'd1;
`endif
endmodule
